// File: rtl/prio_enc_pkg.sv
// Shared definitions for the 8-to-3 priority encoder and its decoder companion.
// Holds the default vector width, the decoder FSM state type and the index type.
package prio_enc_pkg;

  localparam int PRIO_OUT_W = 8;
  localparam int PRIO_IDX_W = $clog2(PRIO_OUT_W);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } prio_dec_state_t;

  typedef logic [PRIO_IDX_W-1:0] prio_idx_t;

endpackage

// File: rtl/prio_index_decoder_if.sv
// Index-beat input stream plus rebuilt-vector output stream of prio_index_decoder.
// master: the side that produces beats and consumes vectors; slave: the decoder.
interface prio_index_decoder_if
  import prio_enc_pkg::*;
#(
  parameter int OUT_W = PRIO_OUT_W,
  parameter int IDX_W = $clog2(OUT_W)
);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_zero;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;
  logic [IDX_W:0]   out_count;
  logic             out_err;

  modport master (
    output in_valid, in_idx, in_zero, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_zero, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_err
  );

endinterface

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder with range guard.
// An index at or beyond OUT_W yields an all-zero vector and in_range=0.
module onehot_dec #(
  parameter int OUT_W = 8,
  parameter int IDX_W = $clog2(OUT_W)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot,
  output logic             in_range
);

  // one comparator per output bit; out-of-range codes match no bit
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
      assign onehot[gi] = (idx == IDX_W'(gi));
    end
  endgenerate

  // for power-of-two widths every code is legal, so skip the compare
  generate
    if ((1 << IDX_W) == OUT_W) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = ({1'b0, idx} < (IDX_W+1)'(OUT_W));
    end
  endgenerate

endmodule

// File: rtl/prio_index_decoder.sv
// Rebuilds an OUT_W-bit vector from a framed stream of bit indices by OR-ing
// one-hot decodes, then holds the vector and a saturating beat count until
// the consumer takes it.
// Optional build macro PRIO_IDX_DEC_ORDER_CHECK_EN: enforces strictly
// descending index order within a frame and reports violations on out_err.
module prio_index_decoder
  import prio_enc_pkg::*;
#(
  parameter int OUT_W = PRIO_OUT_W,
  parameter int IDX_W = $clog2(OUT_W)
) (
  input logic                 clk,
  input logic                 rst_n,
  prio_index_decoder_if.slave bus
);

  localparam logic [0:0]   ST_ACCUM = ACCUM;
  localparam logic [0:0]   ST_HOLD  = HOLD;
  localparam logic [IDX_W:0] CNT_MAX = '1;

  logic [0:0]       state_reg;
  logic [OUT_W-1:0] vec_reg;
  logic [IDX_W:0]   count_reg;

  logic [OUT_W-1:0] dec_onehot;
  logic             dec_in_range;
  logic             accept;
  logic             idx_beat;
  logic             out_hs;

  onehot_dec #(
    .OUT_W (OUT_W),
    .IDX_W (IDX_W)
  ) u_onehot_dec (
    .idx      (bus.in_idx),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  // handshakes are qualified by the registered state only
  assign accept   = bus.in_valid && (state_reg == ST_ACCUM);
  assign idx_beat = accept && !bus.in_zero;
  assign out_hs   = (state_reg == ST_HOLD) && bus.out_ready;

  // FSM, vector accumulator and saturating beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_ACCUM;
      vec_reg   <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (idx_beat) begin
            vec_reg <= vec_reg | dec_onehot;
            if (count_reg != CNT_MAX) begin
              count_reg <= count_reg + (IDX_W+1)'(1);
            end
          end
          if (accept && bus.in_last) begin
            state_reg <= ST_HOLD;
          end
        end
        default: begin
          if (out_hs) begin
            vec_reg   <= '0;
            count_reg <= '0;
            state_reg <= ST_ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_ACCUM);
  assign bus.out_valid = (state_reg == ST_HOLD);
  assign bus.out_vec   = vec_reg;
  assign bus.out_count = count_reg;

`ifdef PRIO_IDX_DEC_ORDER_CHECK_EN
  logic [IDX_W-1:0] last_idx_reg;
  logic             have_idx_reg;
  logic             seen_zero_reg;
  logic             err_reg;
  logic             order_bad;

  // a non-zero beat is illegal if out of range, after a zero beat,
  // or not strictly below the previous non-zero index
  assign order_bad = !dec_in_range || seen_zero_reg ||
                     (have_idx_reg && (bus.in_idx >= last_idx_reg));

  // order tracking and sticky error, cleared by the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_reg  <= '0;
      have_idx_reg  <= 1'b0;
      seen_zero_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (out_hs) begin
      last_idx_reg  <= '0;
      have_idx_reg  <= 1'b0;
      seen_zero_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (accept) begin
      if (bus.in_zero) begin
        seen_zero_reg <= 1'b1;
      end else begin
        last_idx_reg <= bus.in_idx;
        have_idx_reg <= 1'b1;
        if (order_bad) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  // partial-frame errors stay hidden until the frame is presented
  assign bus.out_err = err_reg && (state_reg == ST_HOLD);
`else
  logic unused_range;
  assign unused_range = dec_in_range;
  assign bus.out_err  = 1'b0;
`endif

endmodule

// File: tb/tb_prio_index_decoder.sv
// Self-checking bench for prio_index_decoder: directed frames from the test
// plan plus randomized frames compared against a frame-level reference model.
module tb_prio_index_decoder;
  import prio_enc_pkg::*;

  localparam int OUT_W   = 8;
  localparam int IDX_W   = $clog2(OUT_W);
  localparam int CNT_MAX = (1 << (IDX_W + 1)) - 1;

  typedef struct {
    int idx;
    bit zero;
    bit last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;
  beat_t frame_q[$];

  always #5 clk = ~clk;

  prio_index_decoder_if #(.OUT_W(OUT_W)) bus ();

  prio_index_decoder #(.OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input bit zero, input bit last);
    beat_t b;
    b.idx = idx;
    b.zero = zero;
    b.last = last;
    frame_q.push_back(b);
  endtask

  // frame-level reference: OR of indices, saturating count, order rules
  task automatic model(output logic [OUT_W-1:0] ev, output int ec, output bit eer);
    int last;
    bit sz;
    ev = '0; ec = 0; eer = 0; last = -1; sz = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i].zero) begin
        sz = 1;
      end else begin
        if (frame_q[i].idx < OUT_W) ev[frame_q[i].idx] = 1'b1;
        else eer = 1;
        if (ec < CNT_MAX) ec++;
        if (sz || (last >= 0 && frame_q[i].idx >= last)) eer = 1;
        last = frame_q[i].idx;
      end
    end
`ifndef PRIO_IDX_DEC_ORDER_CHECK_EN
    eer = 0;
`endif
  endtask

  task automatic drive_beat(input beat_t b);
    bus.in_valid = 1'b1;
    bus.in_idx   = IDX_W'(b.idx);
    bus.in_zero  = b.zero;
    bus.in_last  = b.last;
  endtask

  // present the current beat until accepted (bounded)
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // check the held result for hold_cycles, then complete the handshake
  task automatic drain(input string tag, input int hold_cycles);
    logic [OUT_W-1:0] ev;
    int ec;
    bit eer;
    model(ev, ec, eer);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_in_ready_hold"}, 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < hold_cycles; c++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_stall_vec"}, 32'(bus.out_vec), 32'(ev));
    end
    chk({tag, "_vec"}, 32'(bus.out_vec), 32'(ev));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(ec));
    chk({tag, "_err"}, 32'(bus.out_err), 32'(eer));
    $display("frame %0d %s beats=%0d vec=%b count=%0d err=%0d", frame_no, tag,
             frame_q.size(), bus.out_vec, bus.out_count, bus.out_err);
    frame_no++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_frame(input string tag, input int hold_cycles, input bit gaps);
    foreach (frame_q[i]) begin
      drive_beat(frame_q[i]);
      wait_accept(tag);
      bus.in_valid = 1'b0;
      if (!frame_q[i].last && gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk({tag, "_gap_valid"}, 32'(bus.out_valid), 32'd0);
      end
    end
    drain(tag, hold_cycles);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_vec"}, 32'(bus.out_vec), 32'd0);
    chk({tag, "_count"}, 32'(bus.out_count), 32'd0);
    chk({tag, "_err"}, 32'(bus.out_err), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_zero   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset_rel");

    // 7,3,0 -> 1000_1001
    frame_q.delete();
    push(7, 0, 0); push(3, 0, 0); push(0, 0, 1);
    run_frame("desc_730", 0, 0);

    // single zero+last beat
    frame_q.delete();
    push(5, 1, 1);
    run_frame("zero_only", 0, 0);

    // ascending 2,5
    frame_q.delete();
    push(2, 0, 0); push(5, 0, 1);
    run_frame("asc_25", 1, 0);

    // stall in HOLD with the next frame's beat already presented
    frame_q.delete();
    push(7, 0, 1);
    drive_beat(frame_q[0]);
    wait_accept("stall");
    push(4, 0, 1);
    drive_beat(frame_q[1]);
    frame_q.delete();
    push(7, 0, 1);
    drain("stall_a", 5);
    // the held beat is taken on the edge after the handshake
    frame_q.delete();
    push(4, 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain("stall_b", 0);

    // ten duplicate beats, and saturation with twenty
    frame_q.delete();
    for (int i = 0; i < 10; i++) push(1, 0, i == 9);
    run_frame("dup10", 0, 0);
    frame_q.delete();
    for (int i = 0; i < 20; i++) push(1, 0, i == 19);
    run_frame("dup20_sat", 0, 0);

    // asynchronous reset mid-frame
    frame_q.delete();
    push(6, 0, 0); push(5, 0, 0);
    foreach (frame_q[i]) begin
      drive_beat(frame_q[i]);
      wait_accept("rst_mid");
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame_q.delete();
    push(0, 0, 1);
    run_frame("after_rst", 0, 0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      frame_q.delete();
      if ($urandom_range(0, 1) == 1) begin
        for (int b = OUT_W - 1; b >= 0; b--) begin
          if ($urandom_range(0, 1) == 1) push(b, 0, 0);
        end
        if (frame_q.size() == 0 || $urandom_range(0, 2) == 0) push($urandom_range(0, OUT_W - 1), 1, 0);
      end else begin
        int len = $urandom_range(1, 18);
        for (int i = 0; i < len; i++) push($urandom_range(0, OUT_W - 1), $urandom_range(0, 5) == 0, 0);
      end
      frame_q[frame_q.size() - 1].last = 1'b1;
      run_frame("rand", $urandom_range(0, 3), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
